// File: rtl/text_pkg.sv
// text_pkg: constants shared by the UART text buffer reader and writer.
// No ports. Holds text grid geometry, RAM address widths, the default blank
// character, and the per-character inverse-video attribute bit.
package text_pkg;

  localparam int COLS    = 32;
  localparam int ROWS    = 4;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam int COL_AW  = 5;
  localparam int ROW_AW  = 2;

  localparam int WIN_W   = COLS * GLYPH_W;
  localparam int WIN_H   = ROWS * GLYPH_H;

  localparam logic [6:0] BLANK_CODE_DEF = 7'h20;

  // Bit 7 of a RAM byte marks the character as inverse video; [6:0] is ASCII.
  localparam int ATTR_BIT = 7;

  // State carried from the address stage to the output stage.
  typedef struct packed {
    logic       in_win;
    logic       video_on;
    logic [3:0] glyph_row;
    logic [2:0] glyph_col;
  } stage1_t;

endpackage

// File: rtl/frame_blink.sv
// frame_blink: frame counter and cursor blink bit.
// Ports:
//   clk, reset (sync, active low), p_tick (pixel enable),
//   x, y (scan position), blink (counter MSB, toggles every 2^BLINK_LOG2 frames).
// A frame is counted on the pixel tick at scan position (0,0).
module frame_blink #(
  parameter int BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       blink
);

  logic [BLINK_LOG2:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (p_tick && (x == 10'd0) && (y == 10'd0)) begin
      r_frame_cnt <= r_frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
    end
  end

  assign blink = r_frame_cnt[BLINK_LOG2];

endmodule

// File: rtl/text_buffer_reader.sv
// text_buffer_reader: read side of the UART text buffer.
// Converts the VGA scan position into a character-cell address for the
// 32x4 character RAM, captures the returned byte one pixel later and
// presents ASCII code, glyph offsets and inverse flag aligned to a 2-tick
// delayed copy of video_on.
// Ports:
//   clk, reset (sync, active low), p_tick (pixel enable, 1 clk wide)
//   video_on, x, y           : scan position from the VGA controller
//   ry, rx / rdata           : RAM read address / data (1 clk latency)
//   cur_y, cur_x             : writer cursor cell (cursor build only)
//   ascii_code, glyph_row, glyph_col, inverse, video_on_d : aligned outputs
// Build option: define TBR_CURSOR_EN for a blinking underline cursor on
// glyph rows 14-15 of the cursor cell. Without it the cursor ports are ignored.
module text_buffer_reader
  import text_pkg::*;
#(
  parameter int         X0         = 64,
  parameter int         Y0         = 208,
  parameter logic [6:0] BLANK_CODE = BLANK_CODE_DEF,
  parameter int         BLINK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ROW_AW-1:0] ry,
  output logic [COL_AW-1:0] rx,
  input  logic [7:0]        rdata,
  input  logic [ROW_AW-1:0] cur_y,
  input  logic [COL_AW-1:0] cur_x,
  output logic [6:0]        ascii_code,
  output logic [3:0]        glyph_row,
  output logic [2:0]        glyph_col,
  output logic              inverse,
  output logic              video_on_d
);

  // Unsigned 10-bit offsets: left/above the window wraps to a large value,
  // so a single upper-bound compare covers both sides.
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_in_win;
  logic       w_cursor_on;

  assign w_dx     = x - 10'(X0);
  assign w_dy     = y - 10'(Y0);
  assign w_in_win = (w_dx < 10'(WIN_W)) && (w_dy < 10'(WIN_H));

  logic [ROW_AW-1:0] r_ry;
  logic [COL_AW-1:0] r_rx;
  stage1_t           r_s1;
  logic [6:0]        r_ascii;
  logic [3:0]        r_glyph_row;
  logic [2:0]        r_glyph_col;
  logic              r_inverse;
  logic              r_video_on_d;

`ifdef TBR_CURSOR_EN
  logic w_blink;

  frame_blink #(
    .BLINK_LOG2(BLINK_LOG2)
  ) u_frame_blink (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick),
    .x     (x),
    .y     (y),
    .blink (w_blink)
  );

  // The held RAM address equals the stage-1 pixel's cell whenever that pixel
  // is in the window, which is the only case where inverse can be set.
  assign w_cursor_on = ({r_ry, r_rx} == {cur_y, cur_x}) && w_blink &&
                       (r_s1.glyph_row >= 4'd14);
`else
  logic w_unused;
  assign w_unused    = ^{cur_x, cur_y};
  assign w_cursor_on = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ry         <= '0;
      r_rx         <= '0;
      r_s1         <= '0;
      r_ascii      <= BLANK_CODE;
      r_glyph_row  <= '0;
      r_glyph_col  <= '0;
      r_inverse    <= 1'b0;
      r_video_on_d <= 1'b0;
    end else if (p_tick) begin
      if (w_in_win) begin
        r_rx <= w_dx[7:3];
        r_ry <= w_dy[5:4];
      end
      r_s1.in_win    <= w_in_win;
      r_s1.video_on  <= video_on;
      r_s1.glyph_row <= w_dy[3:0];
      r_s1.glyph_col <= w_dx[2:0];

      // rdata has settled for the address issued on the previous tick.
      r_ascii      <= r_s1.in_win ? rdata[6:0] : BLANK_CODE;
      r_inverse    <= r_s1.in_win & (rdata[ATTR_BIT] ^ w_cursor_on);
      r_glyph_row  <= r_s1.glyph_row;
      r_glyph_col  <= r_s1.glyph_col;
      r_video_on_d <= r_s1.video_on;
    end
  end

  assign ry         = r_ry;
  assign rx         = r_rx;
  assign ascii_code = r_ascii;
  assign glyph_row  = r_glyph_row;
  assign glyph_col  = r_glyph_col;
  assign inverse    = r_inverse;
  assign video_on_d = r_video_on_d;

endmodule

// File: tb/tb_text_buffer_reader.sv
// Self-checking bench for text_buffer_reader. A pixel-level reference model
// tracks the cell and glyph offsets of the pixel in flight and derives the
// expected outputs from the window geometry and RAM contents.
// Define TBR_CURSOR_EN to also exercise the blinking cursor.
module tb_text_buffer_reader;

  localparam int X0 = 64;
  localparam int Y0 = 208;
  localparam int BL = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic [1:0] ry;
  logic [4:0] rx;
  logic [7:0] rdata = '0;
  logic [1:0] cur_y = 2'd1;
  logic [4:0] cur_x = 5'd3;
  logic [6:0] ascii_code;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic       inverse;
  logic       video_on_d;

  text_buffer_reader #(
    .X0(X0), .Y0(Y0), .BLANK_CODE(7'h20), .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .ry(ry), .rx(rx), .rdata(rdata),
    .cur_y(cur_y), .cur_x(cur_x),
    .ascii_code(ascii_code), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .inverse(inverse), .video_on_d(video_on_d)
  );

  always #5 clk = ~clk;

  // Character RAM with a registered read port.
  logic [7:0] ram [4][32];
  always @(posedge clk) rdata <= ram[ry][rx];

  int checks = 0;
  int errors = 0;

  // Reference model: pixel currently in stage 1, last in-window cell, frames.
  bit         m_in;
  bit         m_v;
  int         m_row, m_col;
  logic [3:0] m_grow;
  logic [2:0] m_gcol;
  int         m_rx, m_ry;
  int         m_fc;

  task automatic model_reset();
    m_in = 0; m_v = 0; m_row = 0; m_col = 0;
    m_grow = '0; m_gcol = '0; m_rx = 0; m_ry = 0; m_fc = 0;
  endtask

  task automatic do_tick(input int px, input int py, input bit pv);
    int dxi, dyi;
    bit pin, cur;
    logic [7:0] b;
    logic [6:0] e_code;
    bit e_inv;
    @(negedge clk);
    x = px[9:0]; y = py[9:0]; video_on = pv; p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    dxi = px - X0;
    dyi = py - Y0;
    pin = (dxi >= 0) && (dxi < 256) && (dyi >= 0) && (dyi < 64);
    b = ram[m_row][m_col];
    cur = 0;
`ifdef TBR_CURSOR_EN
    cur = (m_row == int'(cur_y)) && (m_col == int'(cur_x)) &&
          (((m_fc % 64) / 32) == 1) && (m_grow >= 4'd14);
`endif
    e_code = m_in ? b[6:0] : 7'h20;
    e_inv  = m_in && (b[7] ^ cur);
    checks++;
    if (ascii_code !== e_code) begin
      errors++; $display("FAIL ascii_code px=%0d py=%0d got %h want %h", px, py, ascii_code, e_code);
    end
    checks++;
    if (inverse !== e_inv) begin
      errors++; $display("FAIL inverse px=%0d py=%0d got %b want %b", px, py, inverse, e_inv);
    end
    checks++;
    if (video_on_d !== m_v) begin
      errors++; $display("FAIL video_on_d got %b want %b", video_on_d, m_v);
    end
    checks++;
    if (glyph_row !== m_grow || glyph_col !== m_gcol) begin
      errors++; $display("FAIL glyph got row %0d col %0d want row %0d col %0d",
                         glyph_row, glyph_col, m_grow, m_gcol);
    end
    if (pin) begin
      m_col = dxi / 8; m_row = dyi / 16; m_rx = m_col; m_ry = m_row;
    end
    m_in = pin; m_v = pv;
    m_grow = 4'(dyi & 15);
    m_gcol = 3'(dxi & 7);
    if (px == 0 && py == 0) m_fc++;
    checks++;
    if (rx !== 5'(m_rx) || ry !== 2'(m_ry)) begin
      errors++; $display("FAIL ram_addr got ry %0d rx %0d want ry %0d rx %0d", ry, rx, m_ry, m_rx);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) do_tick(X0 + 8 * i + 3, Y0 + 20, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x = 10'(X0 + 8 * i); y = 10'(Y0 + i); video_on = 1'b1;
      p_tick = (i % 4 == 0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ascii_code !== 7'h20 || inverse !== 1'b0 || video_on_d !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ascii %h inv %b vod %b want 20 0 0",
                         ascii_code, inverse, video_on_d);
    end
    checks++;
    if (rx !== 5'd0 || ry !== 2'd0 || glyph_row !== 4'd0 || glyph_col !== 3'd0) begin
      errors++; $display("FAIL reset_addr got rx %0d ry %0d grow %0d gcol %0d want 0",
                         rx, ry, glyph_row, glyph_col);
    end
    @(negedge clk);
    p_tick = 1'b0; reset = 1'b1;
    model_reset();
    do_tick(X0 + 9, Y0 + 1, 1'b1);
    checks++;
    if (ascii_code !== 7'h20) begin
      errors++; $display("FAIL post_reset_blank got %h want 20", ascii_code);
    end
    do_tick(X0 + 10, Y0 + 1, 1'b1);
  endtask

  task automatic test_cell_lookup();
    ram[2][5] = 8'h41;
    do_tick(X0 + 45, Y0 + 37, 1'b1);
    checks++;
    if (rx !== 5'd5 || ry !== 2'd2) begin
      errors++; $display("FAIL cell_addr got ry %0d rx %0d want 2 5", ry, rx);
    end
    do_tick(X0 + 46, Y0 + 37, 1'b1);
    checks++;
    if (ascii_code !== 7'h41 || glyph_col !== 3'd5 || glyph_row !== 4'd5 || inverse !== 1'b0) begin
      errors++; $display("FAIL cell_data got %h col %0d row %0d inv %b want 41 5 5 0",
                         ascii_code, glyph_col, glyph_row, inverse);
    end
  endtask

  task automatic test_last_col();
    ram[0][31] = 8'hC8;
    do_tick(X0 + 255, Y0, 1'b1);
    do_tick(X0 + 256, Y0, 1'b1);
    checks++;
    if (ascii_code !== 7'h48 || inverse !== 1'b1) begin
      errors++; $display("FAIL last_col got %h inv %b want 48 1", ascii_code, inverse);
    end
    do_tick(X0 + 257, Y0, 1'b1);
    checks++;
    if (ascii_code !== 7'h20 || inverse !== 1'b0) begin
      errors++; $display("FAIL past_last_col got %h inv %b want 20 0", ascii_code, inverse);
    end
  endtask

  task automatic test_underflow();
    do_tick(X0 + 100, Y0 + 20, 1'b1);
    do_tick(X0 - 1, Y0 + 10, 1'b1);
    do_tick(X0 + 10, Y0 + 64, 1'b1);
    checks++;
    if (rx !== 5'd12 || ry !== 2'd1 || ascii_code !== 7'h20) begin
      errors++; $display("FAIL underflow got rx %0d ry %0d ascii %h want 12 1 20", rx, ry, ascii_code);
    end
    do_tick(X0 + 10, Y0 - 1, 1'b1);
    checks++;
    if (ascii_code !== 7'h20 || rx !== 5'd12) begin
      errors++; $display("FAIL below_win got ascii %h rx %0d want 20 12", ascii_code, rx);
    end
  endtask

  task automatic test_gating();
    logic [6:0] s_code;
    logic [3:0] s_row;
    logic [2:0] s_col;
    logic [4:0] s_rx;
    logic [1:0] s_ry;
    logic       s_inv, s_vod;
    for (int k = 0; k < 3; k++) begin
      do_tick(X0 + 30 + k, Y0 + 5, 1'b1);
      do_tick(X0 + 31 + k + 8, Y0 + 5, 1'b1);
      s_code = ascii_code; s_row = glyph_row; s_col = glyph_col;
      s_rx = rx; s_ry = ry; s_inv = inverse; s_vod = video_on_d;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        x = 10'($urandom_range(1023)); y = 10'($urandom_range(1023));
        video_on = 1'($urandom_range(1));
      end
      #1;
      checks++;
      if (ascii_code !== s_code || glyph_row !== s_row || glyph_col !== s_col ||
          rx !== s_rx || ry !== s_ry || inverse !== s_inv || video_on_d !== s_vod) begin
        errors++; $display("FAIL gated_hold got ascii %h rx %0d ry %0d want ascii %h rx %0d ry %0d",
                           ascii_code, rx, ry, s_code, s_rx, s_ry);
      end
    end
    do_tick(X0 + 50, Y0 + 6, 1'b1);
    do_tick(X0 + 51, Y0 + 6, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      do_tick(X0 - 20 + int'($urandom_range(300)), Y0 - 10 + int'($urandom_range(84)),
              1'($urandom_range(1)));
    end
  endtask

`ifdef TBR_CURSOR_EN
  task automatic test_cursor();
    int hits;
    hits = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    ram[1][3] = 8'h20;
    ram[1][4] = 8'h20;
    cur_y = 2'd1; cur_x = 5'd3;
    for (int f = 0; f < 64; f++) begin
      do_tick(0, 0, 1'b0);
      for (int r = 12; r < 16; r++) begin
        do_tick(X0 + 24, Y0 + 16 + r, 1'b1);
        if (inverse === 1'b1) hits++;
        do_tick(X0 + 31, Y0 + 16 + r, 1'b1);
        if (inverse === 1'b1) hits++;
        do_tick(X0 + 32, Y0 + 16 + r, 1'b1);
        if (inverse === 1'b1) hits++;
      end
    end
    do_tick(0, 0, 1'b0);
    if (inverse === 1'b1) hits++;
    do_tick(0, 0, 1'b0);
    if (inverse === 1'b1) hits++;
    // 32 blink-on frames x 2 underline rows x 2 pixels of the cursor cell.
    checks++;
    if (hits != 128) begin
      errors++; $display("FAIL cursor_hits got %0d want 128", hits);
    end
  endtask
`endif

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) ram[r][c] = 8'($urandom_range(255));
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_cell_lookup();
    test_last_col();
    test_underflow();
    test_gating();
    test_random();
`ifdef TBR_CURSOR_EN
    test_cursor();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buffer_reader.md
# text_buffer_reader

Read side of the UART text buffer. Tracks the VGA scan position, computes the character-cell address for the 32×4 character RAM's read port, and captures the returned byte. It delivers an ASCII code with glyph row/column offsets, pipelined and aligned to the pixel stream, to the text-generation circuit. It sits between the VGA controller, the RAM read port (`ry`/`rx`/`rdata`), and the font/text generator; the UART writer owns the other RAM port.

## Interface
Parameters:
- `X0`, default 64: left pixel of the text window.
- `Y0`, default 208: top pixel of the text window.
- `BLANK_CODE`, default 7'h20: code emitted outside the window.
- `BLINK_LOG2`, default 5: cursor blink half-period is 2^BLINK_LOG2 frames.

Ports (clock and reset first):
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: synchronous, active-low reset.
- `p_tick` in 1: pixel-enable strobe from the VGA controller, one `clk` wide, every 4th cycle.
- `video_on` in 1: visible-area flag for the current pixel.
- `x` in 10: current pixel column.
- `y` in 10: current pixel row.
- `ry` out 2: RAM read row.
- `rx` out 5: RAM read column.
- `rdata` in 8: RAM read data, valid 1 `clk` after `ry`/`rx` change.
- `cur_y` in 2: writer cursor row (used only with the macro).
- `cur_x` in 5: writer cursor column (used only with the macro).
- `ascii_code` out 7: character for the aligned pixel.
- `glyph_row` out 4: pixel row within the 8×16 glyph.
- `glyph_col` out 3: pixel column within the glyph.
- `inverse` out 1: render the pixel inverted.
- `video_on_d` out 1: `video_on` delayed to match the other outputs.

## Operation
- Window: 32 cols × 8 px = 256 px wide; 4 rows × 16 px = 64 px tall.
  - `in_win` = (x − X0) in [0,255] and (y − Y0) in [0,63].
  - Subtraction is 10-bit unsigned; an underflow gives a value ≥256 or ≥64, so the pixel is outside the window.
- Stage 1 (on `p_tick`):
  - `rx` ← (x−X0)[7:3]; `ry` ← (y−Y0)[5:4].
  - Register `glyph_col` ← (x−X0)[2:0], `glyph_row` ← (y−Y0)[3:0], `in_win`, `video_on`.
  - Outside the window, `rx`/`ry` hold their previous values.
- Stage 2 (on the next `p_tick`):
  - `ascii_code` ← `in_win` ? `rdata[6:0]` : BLANK_CODE.
  - `inverse` ← `in_win` & (`rdata[7]` XOR `cursor_on`).
  - `video_on_d`, `glyph_row` and `glyph_col` move forward one stage.
- `rdata[7]` is a per-character inverse-video attribute; bits [6:0] are ASCII.
- Frame counter: increments on the `p_tick` where x==0 and y==0. Width is BLINK_LOG2+1 bits and it wraps.
- Reset values (reset low at a `clk` edge):
  - `rx`=0, `ry`=0, `ascii_code`=BLANK_CODE, `glyph_row`=0, `glyph_col`=0, `inverse`=0, `video_on_d`=0.
  - Frame counter = 0; pipeline `in_win` flags = 0.
- Reset mid-line: outputs are blank until two `p_tick`s after reset is released.
- Cycles without `p_tick`: all registers hold.

## Timing
- Latency is exactly 2 `p_tick`s from (x, y, video_on) to the aligned outputs. The downstream rgb register adds its own stage.
- The RAM read is issued on the stage-1 `p_tick`. `rdata` is sampled 4 `clk` later, on the stage-2 `p_tick`, which covers the 1-`clk` RAM latency.
- Cell boundary: when x crosses X0+8k, `rx` updates on that `p_tick`. The new character appears at the outputs 2 `p_tick`s later.
- Last column (x = X0+255): `in_win` is still 1. At x = X0+256, `in_win`=0 and the outputs become blank 2 `p_tick`s later.
- Simultaneous UART write to the cell being read: the reader returns either the old or the new byte. No tearing guarantee beyond that; the RAM resolves the collision.

## Configuration
- `TBR_CURSOR_EN` defined:
  - `cursor_on` = (stage-1 `ry`,`rx`) == (`cur_y`,`cur_x`) & frame_counter[BLINK_LOG2] & (`glyph_row` ≥ 14).
  - Result is an underline cursor that blinks with a 2^(BLINK_LOG2+1)-frame period.
- Not defined:
  - `cursor_on` = 0; the frame counter is not instantiated.
  - `cur_x`/`cur_y` remain as ports and are ignored.

## Structure
- Shared package `text_pkg` holds:
  - COLS=32, ROWS=4, GLYPH_W=8, GLYPH_H=16.
  - Address widths (col 5, row 2).
  - Default BLANK_CODE.
  - The attribute-bit index (7).
- The UART writer uses the same package for its cursor wrap.
- One sub-module: `frame_blink`. It holds the frame counter and blink bit, is instantiated only under `TBR_CURSOR_EN`, and takes inputs `clk`, `reset`, `p_tick`, `x`, `y`.

## Test plan
- Reset held low for 10 `clk` while x/y sweep → `ascii_code`=7'h20, `inverse`=0, `video_on_d`=0; `rx`=0, `ry`=0.
- RAM model with cell (2,5)=8'h41; scan pixel x=X0+45, y=Y0+37 → `rx`=5, `ry`=2 after 1 `p_tick`. After 2 `p_tick`s: `ascii_code`=7'h41, `glyph_col`=5, `glyph_row`=5, `inverse`=0.
- Cell (0,31)=8'hC8; pixel x=X0+255, y=Y0 → `ascii_code`=7'h48, `inverse`=1. Next pixel x=X0+256 → `ascii_code`=7'h20, 2 `p_tick`s later.
- x=X0−1 (underflow) and y=Y0+64 → blank output, and `rx`/`ry` unchanged from their prior values.
- `TBR_CURSOR_EN` on; cursor (1,3); cell (1,3)=8'h20; run 64 frames → `inverse`=1 only on glyph rows 14–15 of that cell, and only in frames 32–63 of each 64-frame period.
- `p_tick` gated off for 20 `clk` mid-line → all outputs constant; the pipeline resumes with no dropped or duplicated pixel.
